// File: rtl/seq_alu_exec.sv
// Multi-cycle ALU execute unit. Logic and arithmetic ops complete in one cycle.
// Shifts step one bit per cycle through an accumulator before the result is registered.
module seq_alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal_op,
    output logic             busy
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;

    logic               is_shift;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   acc_next;

    // Single-cycle ops; a shift only reaches here with a zero amount, so it passes A through.
    // Illegal codes fall into the default and behave as ADD.
    function automatic logic [WIDTH-1:0] alu_single(input logic [3:0]       op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OP_SUB:                 return a - b;
            OP_AND:                 return a & b;
            OP_OR:                  return a | b;
            OP_XOR:                 return a ^ b;
            OP_SLT:                 return {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU:                return {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL, OP_SRL, OP_SRA: return a;
            default:                return a + b;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(input logic [3:0]       op,
                                                   input logic [WIDTH-1:0] v);
        case (op)
            OP_SLL:  return {v[WIDTH-2:0], 1'b0};
            OP_SRL:  return {1'b0, v[WIDTH-1:1]};
            OP_SRA:  return {v[WIDTH-1], v[WIDTH-1:1]};
            default: return v;
        endcase
    endfunction

    assign is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                      (ALUControl == OP_SRA);
    assign shamt    = SrcB[SHAMT_W-1:0];
    assign acc_next = shift_one(op_q, acc_q);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;

        case (state_q)
            S_IDLE: begin
                // A flush in IDLE simply suppresses the accept.
                if (in_valid && !flush) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = SrcA;
                        cnt_d   = shamt;
                        op_d    = ALUControl;
                        state_d = S_SHIFT;
                    end else begin
                        result_d  = alu_single(ALUControl, SrcA, SrcB);
                        zero_d    = (result_d == '0);
                        illegal_d = (ALUControl > OP_SRA);
                        state_d   = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_next;
                    cnt_d = cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_d  = acc_next;
                        zero_d    = (acc_next == '0);
                        illegal_d = 1'b0;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    // Shift working registers are only meaningful while in SHIFT.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        op_q  <= op_d;
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign ALUResult  = result_q;
    assign Zero       = zero_q;
    assign illegal_op = illegal_q;

endmodule
